ipsc_multichannel_unit: RTL and testbench

Sequential, multi-channel successor to the combinational IPSC datapath. Computes I = Σc gin_c·(Ein_c − Vmem)·ΔT/τmem over NUM_CHANNELS synaptic channels (e.g. excitatory/inhibitory) in signed fixed point. One shared serial divider forms K = ΔT/τmem once per request. One shared multiplier pair is time-multiplexed across channels. Sits between the per-neuron conductance state and the membrane-update stage.

---
 rtl/ipsc_pkg.sv | 39 +++
 rtl/ipsc_multichannel_unit_if.sv | 32 +++
 rtl/ipsc_serial_divider.sv | 68 ++++++
 rtl/ipsc_multichannel_unit.sv | 153 +++++++++++++++
 tb/tb_ipsc_multichannel_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/ipsc_pkg.sv
// Shared types, default widths and fixed-point helpers for the multi-channel IPSC unit.
package ipsc_pkg;

  localparam int unsigned IntegerWidthDef  = 32;
  localparam int unsigned DataWidthFracDef = 32;
  localparam int unsigned DeltaTWidthDef   = 4;
  localparam int unsigned NumChannelsDef   = 2;

  // Widest Q-format value the helpers below can handle.
  localparam int unsigned FxMaxWidth = 128;

  typedef enum logic [2:0] {
    StIdle,
    StDiv,
    StChMul1,
    StChMul2,
    StDone
  } ipsc_state_e;

  // Full-precision signed product, arithmetically shifted right by frac; the caller truncates
  // to its own width, which yields the [W+frac-1:frac] slice (floor).
  function automatic logic signed [FxMaxWidth-1:0] fx_mul(
    input logic signed [FxMaxWidth-1:0] a,
    input logic signed [FxMaxWidth-1:0] b,
    input int unsigned                  frac
  );
    logic signed [2*FxMaxWidth-1:0] prod;
    prod = (2*FxMaxWidth)'(a) * (2*FxMaxWidth)'(b);
    return FxMaxWidth'(prod >>> frac);
  endfunction

  // Most negative (neg=1) or most positive (neg=0) two's-complement value of the given width.
  function automatic logic [FxMaxWidth-1:0] sat_limit(input int unsigned width, input logic neg);
    logic [FxMaxWidth-1:0] top_bit;
    top_bit = FxMaxWidth'(1) << (width - 1);
    return neg ? top_bit : top_bit - FxMaxWidth'(1);
  endfunction

endpackage

// File: rtl/ipsc_multichannel_unit_if.sv
// Request/response bundle between the conductance state and the IPSC unit.
interface ipsc_multichannel_unit_if #(
  parameter int unsigned INTEGER_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH_FRAC = 32,
  parameter int unsigned DELTAT_WIDTH    = 4,
  parameter int unsigned NUM_CHANNELS    = 2
) ();
  localparam int unsigned DATA_WIDTH = INTEGER_WIDTH + DATA_WIDTH_FRAC;

  logic                                  start;
  logic [NUM_CHANNELS-1:0]               channel_enable;
  logic [DATA_WIDTH-1:0]                 vmem;
  logic [DELTAT_WIDTH-1:0]               delta_t;
  logic [INTEGER_WIDTH-1:0]              taumem;
  logic [NUM_CHANNELS*INTEGER_WIDTH-1:0] ein_bus;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    gin_bus;
  logic                                  busy;
  logic                                  done;
  logic [DATA_WIDTH-1:0]                 ipsc_out;
  logic                                  overflow;
  logic                                  div_error;

  modport master (
    output start, channel_enable, vmem, delta_t, taumem, ein_bus, gin_bus,
    input  busy, done, ipsc_out, overflow, div_error
  );

  modport slave (
    input  start, channel_enable, vmem, delta_t, taumem, ein_bus, gin_bus,
    output busy, done, ipsc_out, overflow, div_error
  );
endinterface

// File: rtl/ipsc_serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, fixed DividendWidth-cycle latency.
module ipsc_serial_divider #(
  parameter int unsigned DividendWidth = 32,
  parameter int unsigned DivisorWidth  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [DividendWidth-1:0] dividend_i,
  input  logic [DivisorWidth-1:0]  divisor_i,
  output logic                     done_o,
  output logic [DividendWidth-1:0] quotient_o
);
  localparam int unsigned CntW = (DividendWidth > 1) ? $clog2(DividendWidth) : 1;

  logic [DividendWidth-1:0] quo_q, quo_d;
  logic [DivisorWidth-1:0]  rem_q, rem_d, dvs_q, dvs_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic [DivisorWidth:0]    shifted, diff;

  always_comb begin
    shifted = {rem_q, quo_q[DividendWidth-1]};
    diff    = shifted - {1'b0, dvs_q};
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_o  = busy_q && (cnt_q == CntW'(DividendWidth - 1));
    if (start_i) begin
      quo_d  = dividend_i;
      rem_d  = '0;
      dvs_d  = divisor_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // A set MSB in diff means the trial subtraction went negative: restore.
      if (!diff[DivisorWidth]) begin
        rem_d = diff[DivisorWidth-1:0];
        quo_d = {quo_q[DividendWidth-2:0], 1'b1};
      end else begin
        rem_d = shifted[DivisorWidth-1:0];
        quo_d = {quo_q[DividendWidth-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
      if (done_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign quotient_o = quo_q;
endmodule

// File: rtl/ipsc_multichannel_unit.sv
// Sequential multi-channel IPSC: I = sum_c gin_c*(Ein_c - Vmem)*dT/tau, with one shared divider
// and one multiplier pair walked across the channels.
module ipsc_multichannel_unit
  import ipsc_pkg::*;
#(
  parameter int unsigned INTEGER_WIDTH   = IntegerWidthDef,
  parameter int unsigned DATA_WIDTH_FRAC = DataWidthFracDef,
  parameter int unsigned DELTAT_WIDTH    = DeltaTWidthDef,
  parameter int unsigned NUM_CHANNELS    = NumChannelsDef,
  parameter bit          SATURATE        = 1'b1
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  ipsc_multichannel_unit_if.slave bus_io
);
  localparam int unsigned DATA_WIDTH = INTEGER_WIDTH + DATA_WIDTH_FRAC;
  localparam int unsigned ChW        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [ChW-1:0] LastCh  = ChW'(NUM_CHANNELS - 1);

  ipsc_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0]                 vmem_q;
  logic [NUM_CHANNELS*INTEGER_WIDTH-1:0] ein_q;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    gin_q;
  logic [NUM_CHANNELS-1:0]               en_q;
  logic                                  tau_bad_q;
  logic [ChW-1:0]                        ch_q, ch_d;
  logic signed [DATA_WIDTH-1:0]          p1_q, p1_d, acc_q, acc_d, ipsc_q;
  logic                                  ovf_run_q, ovf_run_d, ovf_q, div_err_q;
  logic                                  done_q, done_d, div_start, div_done;
  logic [DATA_WIDTH_FRAC-1:0]            div_quo;

  logic signed [DATA_WIDTH-1:0]          v1, k_ext, gin_cur, p1, p2;
  logic [INTEGER_WIDTH-1:0]              ein_cur;
  logic signed [DATA_WIDTH:0]            sum;

  ipsc_serial_divider #(
    .DividendWidth(DATA_WIDTH_FRAC),
    .DivisorWidth (INTEGER_WIDTH)
  ) u_divider (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (div_start),
    .dividend_i({bus_io.delta_t, {(DATA_WIDTH_FRAC - DELTAT_WIDTH){1'b0}}}),
    .divisor_i (bus_io.taumem),
    .done_o    (div_done),
    .quotient_o(div_quo)
  );

  assign ein_cur = ein_q[ch_q*INTEGER_WIDTH +: INTEGER_WIDTH];
  assign gin_cur = gin_q[ch_q*DATA_WIDTH +: DATA_WIDTH];
  assign v1      = {ein_cur, {DATA_WIDTH_FRAC{1'b0}}} - vmem_q;
  // K < 1, so its integer part is always zero; a non-positive tau forces K to zero.
  assign k_ext   = {{INTEGER_WIDTH{1'b0}}, (tau_bad_q ? '0 : div_quo)};
  assign p1      = DATA_WIDTH'(fx_mul(FxMaxWidth'(v1), FxMaxWidth'(k_ext), DATA_WIDTH_FRAC));
  assign p2      = DATA_WIDTH'(fx_mul(FxMaxWidth'(p1_q), FxMaxWidth'(gin_cur), DATA_WIDTH_FRAC));
  assign sum     = {acc_q[DATA_WIDTH-1], acc_q} + {p2[DATA_WIDTH-1], p2};

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    p1_d      = p1_q;
    acc_d     = acc_q;
    ovf_run_d = ovf_run_q;
    done_d    = 1'b0;
    div_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          div_start = 1'b1;
          ch_d      = '0;
          acc_d     = '0;
          ovf_run_d = 1'b0;
          state_d   = StDiv;
        end
      end
      StDiv: begin
        if (div_done) state_d = StChMul1;
      end
      StChMul1: begin
        p1_d    = p1;
        state_d = StChMul2;
      end
      StChMul2: begin
        if (en_q[ch_q]) begin
          if (SATURATE && (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])) begin
            acc_d     = DATA_WIDTH'(sat_limit(DATA_WIDTH, sum[DATA_WIDTH]));
            ovf_run_d = 1'b1;
          end else begin
            acc_d = sum[DATA_WIDTH-1:0];
          end
        end
        if (ch_q == LastCh) begin
          state_d = StDone;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = StChMul1;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      vmem_q    <= '0;
      ein_q     <= '0;
      gin_q     <= '0;
      en_q      <= '0;
      tau_bad_q <= 1'b0;
      ch_q      <= '0;
      p1_q      <= '0;
      acc_q     <= '0;
      ovf_run_q <= 1'b0;
      done_q    <= 1'b0;
      ipsc_q    <= '0;
      ovf_q     <= 1'b0;
      div_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      p1_q      <= p1_d;
      acc_q     <= acc_d;
      ovf_run_q <= ovf_run_d;
      done_q    <= done_d;
      if (div_start) begin
        vmem_q    <= bus_io.vmem;
        ein_q     <= bus_io.ein_bus;
        gin_q     <= bus_io.gin_bus;
        en_q      <= bus_io.channel_enable;
        tau_bad_q <= bus_io.taumem[INTEGER_WIDTH-1] || (bus_io.taumem == '0);
        ovf_q     <= 1'b0;
        div_err_q <= 1'b0;
      end
      if (done_d) begin
        ipsc_q    <= acc_q;
        ovf_q     <= ovf_run_q;
        div_err_q <= tau_bad_q;
      end
    end
  end

  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.done      = done_q;
  assign bus_io.ipsc_out  = ipsc_q;
  assign bus_io.overflow  = ovf_q;
  assign bus_io.div_error = div_err_q;
endmodule

// File: tb/tb_ipsc_multichannel_unit.sv
// Directed bench for ipsc_multichannel_unit: one saturating and one wrapping instance share stimulus.
module tb_ipsc_multichannel_unit;
  localparam int unsigned IW = 32;
  localparam int unsigned FW = 32;
  localparam int unsigned DW = IW + FW;
  localparam int unsigned TW = 4;
  localparam int unsigned NC = 2;
  localparam int Latency = FW + 2 * NC + 1;

  localparam logic [DW-1:0] VmemM65 = 64'hFFFFFFBF_00000000;
  localparam logic [DW-1:0] GinOne  = 64'h00000001_00000000;
  localparam logic [IW-1:0] EinM80  = 32'hFFFFFFB0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [NC-1:0]     ch_en;
  logic [DW-1:0]     vmem;
  logic [TW-1:0]     delta_t;
  logic [IW-1:0]     taumem;
  logic [NC*IW-1:0]  ein_bus;
  logic [NC*DW-1:0]  gin_bus;

  ipsc_multichannel_unit_if #(.INTEGER_WIDTH(IW), .DATA_WIDTH_FRAC(FW), .DELTAT_WIDTH(TW),
                              .NUM_CHANNELS(NC)) bus_sat ();
  ipsc_multichannel_unit_if #(.INTEGER_WIDTH(IW), .DATA_WIDTH_FRAC(FW), .DELTAT_WIDTH(TW),
                              .NUM_CHANNELS(NC)) bus_wrap ();

  assign bus_sat.start           = start;
  assign bus_sat.channel_enable  = ch_en;
  assign bus_sat.vmem            = vmem;
  assign bus_sat.delta_t         = delta_t;
  assign bus_sat.taumem          = taumem;
  assign bus_sat.ein_bus         = ein_bus;
  assign bus_sat.gin_bus         = gin_bus;
  assign bus_wrap.start          = start;
  assign bus_wrap.channel_enable = ch_en;
  assign bus_wrap.vmem           = vmem;
  assign bus_wrap.delta_t        = delta_t;
  assign bus_wrap.taumem         = taumem;
  assign bus_wrap.ein_bus        = ein_bus;
  assign bus_wrap.gin_bus        = gin_bus;

  ipsc_multichannel_unit #(.INTEGER_WIDTH(IW), .DATA_WIDTH_FRAC(FW), .DELTAT_WIDTH(TW),
                           .NUM_CHANNELS(NC), .SATURATE(1'b1)) u_dut_sat (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus_sat)
  );

  ipsc_multichannel_unit #(.INTEGER_WIDTH(IW), .DATA_WIDTH_FRAC(FW), .DELTAT_WIDTH(TW),
                           .NUM_CHANNELS(NC), .SATURATE(1'b0)) u_dut_wrap (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus_wrap)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic set_common();
    vmem    = VmemM65;
    delta_t = 4'h8;
    taumem  = 32'd10;
    gin_bus = {GinOne, GinOne};
    ein_bus = {EinM80, 32'h0};
    ch_en   = 2'b11;
  endtask

  // Issues one Start, optionally re-pulses it at cycles pa/pb and scrambles inputs afterwards,
  // then watches a bounded window for Done on both instances.
  task automatic run_txn(input int pa, input int pb, input bit scramble,
                         output int lat, output int lat_w, output int n_done,
                         output logic busy_early, output logic busy_at_done);
    lat = -1; lat_w = -1; n_done = 0; busy_early = 1'b0; busy_at_done = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      vmem    = '0;
      ein_bus = {2{32'h7FFFFFFF}};
      delta_t = 4'hF;
      taumem  = 32'd1;
      ch_en   = 2'b00;
    end
    for (int k = 1; k <= Latency + 30; k++) begin
      @(negedge clk);
      if (k == 1) busy_early = bus_sat.busy;
      if (bus_sat.done) begin
        if (n_done == 0) begin
          lat          = k;
          busy_at_done = bus_sat.busy;
        end
        n_done++;
      end
      if (bus_wrap.done && lat_w < 0) lat_w = k;
      start = (k == pa) || (k == pb);
    end
    start = 1'b0;
  endtask

  task automatic expect_txn(input string tag, input logic [63:0] exp_sat, input logic exp_ovf,
                            input logic [63:0] exp_wrap, input logic exp_derr,
                            input int pa, input int pb, input bit scramble);
    int lat, lat_w, n_done;
    logic busy_early, busy_at_done;
    run_txn(pa, pb, scramble, lat, lat_w, n_done, busy_early, busy_at_done);
    check_val({tag, ".latency"}, 64'(lat), 64'(Latency));
    check_val({tag, ".latency_wrap"}, 64'(lat_w), 64'(Latency));
    check_val({tag, ".done_count"}, 64'(n_done), 64'd1);
    check_val({tag, ".busy_early"}, 64'(busy_early), 64'd1);
    check_val({tag, ".busy_at_done"}, 64'(busy_at_done), 64'd0);
    check_val({tag, ".out"}, bus_sat.ipsc_out, exp_sat);
    check_val({tag, ".ovf"}, 64'(bus_sat.overflow), 64'(exp_ovf));
    check_val({tag, ".out_wrap"}, bus_wrap.ipsc_out, exp_wrap);
    check_val({tag, ".ovf_wrap"}, 64'(bus_wrap.overflow), 64'd0);
    check_val({tag, ".derr"}, 64'(bus_sat.div_error), 64'(exp_derr));
  endtask

  initial begin
    int n_late;
    rst_n = 1'b0;
    start = 1'b0;
    set_common();
    repeat (3) @(negedge clk);
    check_val("rst.busy", 64'(bus_sat.busy), 64'd0);
    check_val("rst.done", 64'(bus_sat.done), 64'd0);
    check_val("rst.out", bus_sat.ipsc_out, 64'd0);
    check_val("rst.ovf", 64'(bus_sat.overflow), 64'd0);
    check_val("rst.derr", 64'(bus_sat.div_error), 64'd0);
    rst_n = 1'b1;

    // 65.0 * K with K = 0x0CCCCCCC.
    set_common();
    ch_en = 2'b01;
    expect_txn("ch0", 64'h00000003_3FFFFFCC, 1'b0, 64'h00000003_3FFFFFCC, 1'b0, -1, -1, 1'b0);

    // Adds -15.0 * K from channel 1.
    set_common();
    expect_txn("both", 64'h00000002_7FFFFFD8, 1'b0, 64'h00000002_7FFFFFD8, 1'b0, -1, -1, 1'b0);

    // -15K * 3/2^32 = -2.25 LSB, floored to -3.
    set_common();
    ch_en   = 2'b10;
    gin_bus = {64'h3, GinOne};
    expect_txn("floor", 64'hFFFFFFFF_FFFFFFFD, 1'b0, 64'hFFFFFFFF_FFFFFFFD, 1'b0, -1, -1, 1'b0);

    set_common();
    taumem = 32'd0;
    expect_txn("tau0", 64'd0, 1'b0, 64'd0, 1'b1, -1, -1, 1'b0);
    set_common();
    taumem = 32'hFFFFFFF6;
    expect_txn("tauneg", 64'd0, 1'b0, 64'd0, 1'b1, -1, -1, 1'b0);

    // V1 wraps to -1.0, each P2 = -0x77FFFFFF_10000000: the sum clamps low.
    vmem    = 64'h80000000_00000000;
    ein_bus = {2{32'h7FFFFFFF}};
    delta_t = 4'hF;
    taumem  = 32'd1;
    gin_bus = {2{64'h7FFFFFFF_00000000}};
    ch_en   = 2'b11;
    expect_txn("sat_neg", 64'h80000000_00000000, 1'b1, 64'h10000001_E0000000, 1'b0, -1, -1, 1'b0);

    // Each P2 = +0x77FFFFFF_10000000: the sum clamps high.
    vmem    = '0;
    gin_bus = {GinOne, GinOne};
    expect_txn("sat_pos", 64'h7FFFFFFF_FFFFFFFF, 1'b1, 64'hEFFFFFFE_20000000, 1'b0, -1, -1, 1'b0);

    // Extra Starts while busy are dropped; result follows the inputs latched at the first one.
    set_common();
    expect_txn("busy_start", 64'h00000002_7FFFFFD8, 1'b0, 64'h00000002_7FFFFFD8, 1'b0, 5, 20, 1'b1);

    // Reset ten cycles into the divide phase.
    set_common();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_val("abort.busy_before", 64'(bus_sat.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("abort.busy", 64'(bus_sat.busy), 64'd0);
    check_val("abort.out", bus_sat.ipsc_out, 64'd0);
    check_val("abort.done", 64'(bus_sat.done), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_late = 0;
    for (int k = 0; k < Latency + 10; k++) begin
      @(negedge clk);
      if (bus_sat.done || bus_wrap.done) n_late++;
    end
    check_val("abort.no_done", 64'(n_late), 64'd0);
    expect_txn("after_abort", 64'h00000002_7FFFFFD8, 1'b0, 64'h00000002_7FFFFFD8, 1'b0, -1, -1,
               1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
